// File: rtl/alu_iterative_exec_if.sv
// Operand/result handshake bundle between the execute stage and the iterative ALU.
// The master drives operands and accepts results; the slave is the ALU itself.
interface alu_iterative_exec_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [5:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            branch_taken;
    logic            zero;

    modport master (
        output flush, in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, branch_taken, zero
    );

    modport slave (
        input  flush, in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, branch_taken, zero
    );
endinterface

// File: rtl/alu_iterative_exec.sv
// RV32I execute ALU: single-cycle arithmetic/logic/compare/branch/pass, with shifts
// performed one bit per cycle in the result register behind a valid/ready handshake.
module alu_iterative_exec #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_iterative_exec_if.slave bus
);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_SLL = 2'd0,
        K_SRL = 2'd1,
        K_SRA = 2'd2
    } shift_kind_t;

    state_t          r_state, w_state_next;
    shift_kind_t     r_kind, w_kind_next;
    logic [XLEN-1:0] r_result, w_result_next;
    logic            r_taken, w_taken_next;
    logic [SW-1:0]   r_count, w_count_next;

    logic [2:0]      w_class;
    logic [2:0]      w_func3;
    logic [SW-1:0]   w_shamt;
    logic            w_is_shift;
    shift_kind_t     w_kind;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic [XLEN-1:0] w_op_result;
    logic            w_op_taken;
    logic [XLEN-1:0] w_shift_step;

    assign w_class = bus.alu_ctrl[5:3];
    assign w_func3 = bus.alu_ctrl[2:0];
    assign w_shamt = bus.op_b[SW-1:0];
    assign w_eq    = (bus.op_a == bus.op_b);
    assign w_lt    = ($signed(bus.op_a) < $signed(bus.op_b));
    assign w_ltu   = (bus.op_a < bus.op_b);

    // Only classes 000/001 carry shifts; class 001 turns SRL into SRA.
    always_comb begin
        w_is_shift = 1'b0;
        w_kind     = K_SLL;
        if (w_class == 3'b000 || w_class == 3'b001) begin
            if (w_func3 == 3'b001) begin
                w_is_shift = 1'b1;
                w_kind     = K_SLL;
            end else if (w_func3 == 3'b101) begin
                w_is_shift = 1'b1;
                w_kind     = w_class[0] ? K_SRA : K_SRL;
            end
        end
    end

    // Single-cycle result; a zero-amount shift falls through to op_a.
    always_comb begin
        w_op_result = '0;
        w_op_taken  = 1'b0;
        case (w_class)
            3'b000, 3'b001: begin
                case (w_func3)
                    3'b000:  w_op_result = w_class[0] ? (bus.op_a - bus.op_b)
                                                      : (bus.op_a + bus.op_b);
                    3'b010:  w_op_result = {{(XLEN-1){1'b0}}, w_lt};
                    3'b011:  w_op_result = {{(XLEN-1){1'b0}}, w_ltu};
                    3'b100:  w_op_result = bus.op_a ^ bus.op_b;
                    3'b110:  w_op_result = bus.op_a | bus.op_b;
                    3'b111:  w_op_result = bus.op_a & bus.op_b;
                    default: w_op_result = bus.op_a;
                endcase
            end
            3'b010: begin
                case (w_func3)
                    3'b000:  w_op_taken = w_eq;
                    3'b001:  w_op_taken = ~w_eq;
                    3'b100:  w_op_taken = w_lt;
                    3'b101:  w_op_taken = ~w_lt;
                    3'b110:  w_op_taken = w_ltu;
                    3'b111:  w_op_taken = ~w_ltu;
                    default: w_op_taken = 1'b0;
                endcase
                w_op_result = {{(XLEN-1){1'b0}}, w_op_taken};
            end
            3'b011:  w_op_result = bus.op_a;
            default: w_op_result = '0;
        endcase
    end

    always_comb begin
        case (r_kind)
            K_SRL:   w_shift_step = {1'b0, r_result[XLEN-1:1]};
            K_SRA:   w_shift_step = {r_result[XLEN-1], r_result[XLEN-1:1]};
            default: w_shift_step = {r_result[XLEN-2:0], 1'b0};
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_kind_next   = r_kind;
        w_result_next = r_result;
        w_taken_next  = r_taken;
        w_count_next  = r_count;
        if (bus.flush) begin
            w_state_next = S_IDLE;
            w_count_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (w_is_shift && (w_shamt != '0)) begin
                            w_result_next = bus.op_a;
                            w_taken_next  = 1'b0;
                            w_count_next  = w_shamt;
                            w_kind_next   = w_kind;
                            w_state_next  = S_SHIFT;
                        end else begin
                            w_result_next = w_op_result;
                            w_taken_next  = w_op_taken;
                            w_state_next  = S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    // The edge that applies the last bit position also enters DONE.
                    w_result_next = w_shift_step;
                    w_count_next  = r_count - SW'(1);
                    if (r_count == SW'(1)) begin
                        w_state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_kind   <= K_SLL;
            r_result <= '0;
            r_taken  <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_kind   <= w_kind_next;
            r_result <= w_result_next;
            r_taken  <= w_taken_next;
            r_count  <= w_count_next;
        end
    end

    assign bus.in_ready     = (r_state == S_IDLE);
    assign bus.out_valid    = (r_state == S_DONE);
    assign bus.result       = r_result;
    assign bus.branch_taken = r_taken;
    assign bus.zero         = (r_result == '0);

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Self-checking bench for alu_iterative_exec: directed corner cases, then random ops
// compared against an arithmetic reference model including expected latency.
module tb_alu_iterative_exec;
    localparam int XLEN = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_iterative_exec_if #(.XLEN(XLEN)) bus_if ();

    alu_iterative_exec #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [5:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic tk, output int lat);
        int         sh;
        logic [2:0] cl;
        logic [2:0] f;
        sh  = int'(b[4:0]);
        cl  = ctrl[5:3];
        f   = ctrl[2:0];
        res = 32'h0;
        tk  = 1'b0;
        lat = 1;
        if (cl == 3'd0 || cl == 3'd1) begin
            case (f)
                3'd0: res = (cl == 3'd1) ? a - b : a + b;
                3'd1: begin res = a << sh; lat = 1 + sh; end
                3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: res = (a < b) ? 32'd1 : 32'd0;
                3'd4: res = a ^ b;
                3'd5: begin
                    res = (cl == 3'd1) ? 32'($signed(a) >>> sh) : (a >> sh);
                    lat = 1 + sh;
                end
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end else if (cl == 3'd2) begin
            case (f)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = ($signed(a) <  $signed(b));
                3'd5: tk = ($signed(a) >= $signed(b));
                3'd6: tk = (a <  b);
                3'd7: tk = (a >= b);
                default: tk = 1'b0;
            endcase
            res = tk ? 32'd1 : 32'd0;
        end else if (cl == 3'd3) begin
            res = a;
        end
    endfunction

    task automatic run_op(input string tag, input logic [5:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        et;
        int          el;
        int          lat;
        model(ctrl, a, b, er, et, el);
        @(negedge clk);
        check({tag, " in_ready_idle"}, 32'(bus_if.in_ready), 32'd1);
        bus_if.in_valid = 1'b1;
        bus_if.alu_ctrl = ctrl;
        bus_if.op_a     = a;
        bus_if.op_b     = b;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        lat = 1;
        while (bus_if.out_valid !== 1'b1 && lat <= 40) begin
            check({tag, " in_ready_busy"}, 32'(bus_if.in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " result"}, bus_if.result, er);
        check({tag, " taken"}, 32'(bus_if.branch_taken), 32'(et));
        check({tag, " zero"}, 32'(bus_if.zero), 32'(er == 32'h0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold_valid"}, 32'(bus_if.out_valid), 32'd1);
            check({tag, " hold_result"}, bus_if.result, er);
            check({tag, " hold_in_ready"}, 32'(bus_if.in_ready), 32'd0);
        end
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        check({tag, " post_valid"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, " post_in_ready"}, 32'(bus_if.in_ready), 32'd1);
        $display("op %s ctrl=%b a=%h b=%h -> result=%h taken=%b lat=%0d", tag, ctrl, a, b,
                 bus_if.result, bus_if.branch_taken, lat);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " in_ready"}, 32'(bus_if.in_ready), 32'd1);
        check({tag, " out_valid"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, " result"}, bus_if.result, 32'h0);
        check({tag, " taken"}, 32'(bus_if.branch_taken), 32'd0);
        check({tag, " zero"}, 32'(bus_if.zero), 32'd1);
    endtask

    initial begin
        logic [5:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        bus_if.flush     = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.alu_ctrl  = 6'd0;
        bus_if.op_a      = 32'h0;
        bus_if.op_b      = 32'h0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        run_op("add_wrap",  6'b000_000, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sub_wrap",  6'b001_000, 32'h0, 32'd1, 0);
        run_op("sra_31",    6'b001_101, 32'h8000_0000, 32'd31, 0);
        run_op("sll_0",     6'b000_001, 32'hDEAD_BEEF, 32'h20, 0);
        run_op("srl_4",     6'b000_101, 32'h8000_00F0, 32'd4, 0);
        run_op("blt",       6'b010_100, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("bltu",      6'b010_110, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("br_f3_010", 6'b010_010, 32'h5, 32'h5, 0);
        run_op("beq",       6'b010_000, 32'h1234, 32'h1234, 0);
        run_op("pass",      6'b011_111, 32'h0000_1004, 32'h55, 0);
        run_op("illegal",   6'b100_000, 32'h1234_5678, 32'h9, 0);
        run_op("slt",       6'b000_010, 32'h8000_0000, 32'h1, 0);
        run_op("backpress", 6'b000_100, 32'hF0F0_1234, 32'h0FF0_0000, 5);

        // flush while a shift is in flight, roughly ten positions remaining
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.alu_ctrl = 6'b000_101;
        bus_if.op_a     = 32'hFFFF_0000;
        bus_if.op_b     = 32'd20;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus_if.flush = 1'b1;
        @(negedge clk);
        bus_if.flush = 1'b0;
        check("flush_shift in_ready", 32'(bus_if.in_ready), 32'd1);
        check("flush_shift out_valid", 32'(bus_if.out_valid), 32'd0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("flush_shift stays_idle", 32'(bus_if.out_valid), 32'd0);
        end
        $display("op flush_mid_shift done");

        // flush together with in_valid in IDLE must not accept
        bus_if.in_valid = 1'b1;
        bus_if.flush    = 1'b1;
        bus_if.alu_ctrl = 6'b000_000;
        bus_if.op_a     = 32'h1;
        bus_if.op_b     = 32'h1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        bus_if.flush    = 1'b0;
        check("flush_accept out_valid", 32'(bus_if.out_valid), 32'd0);
        check("flush_accept in_ready", 32'(bus_if.in_ready), 32'd1);
        $display("op flush_with_valid done");
        run_op("after_flush", 6'b000_110, 32'h0F00_0000, 32'h00F0_000F, 1);

        // asynchronous reset mid-shift
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.alu_ctrl = 6'b001_101;
        bus_if.op_a     = 32'h8000_0000;
        bus_if.op_b     = 32'd31;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        $display("op reset_mid_shift done");
        run_op("after_reset", 6'b000_001, 32'h0000_0003, 32'd30, 0);

        for (int n = 0; n < 40; n++) begin
            rc = 6'($urandom_range(0, 63));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ra;
            run_op("random", rc, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_iterative_exec.md
# alu_iterative_exec

Execute-stage consumer of the 6-bit ALU control code produced by the ALU control decoder in the BURAQ SV32I core. It performs the RV32I arithmetic, logic, compare, branch-condition and pass operations on two operands. Shifts are executed iteratively, one bit position per cycle, to save area on the Arty A7 target. A valid/ready handshake sits on both the operand side and the result side, so the pipeline can stall on a long shift.

## Interface
- XLEN, 32: operand and result width; must be a power of two and at least 8. Shift amount is op_b[$clog2(XLEN)-1:0].
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort of any accepted or in-flight operation.
- in_valid  in  1  operands and code are valid.
- in_ready  out  1  block can accept; high only in IDLE.
- alu_ctrl  in  6  operation code {class[2:0], func3[2:0]}.
- op_a  in  XLEN  operand A (rs1 or PC).
- op_b  in  XLEN  operand B (rs2 or immediate).
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream accepts the result.
- result  out  XLEN  registered result.
- branch_taken  out  1  branch condition; meaningful for class 010 only, 0 otherwise.
- zero  out  1  result == 0.

## Operation
- Class 000: func3 selects the operation.
  - 000 ADD, 001 SLL, 010 SLT (signed), 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - SLT and SLTU return 1 or 0 in bit 0.
- Class 001: 000 SUB, 101 SRA. Any other func3 behaves as its class-000 counterpart.
- Class 010 (branch): result = {XLEN-1 zeros, taken}, and branch_taken = taken.
  - 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
  - func3 010 and 011 give taken = 0.
- Class 011, any func3: result = op_a. This is the pass used for JAL/JALR; the decoder issues 011_111.
- Classes 100–111: result = 0, branch_taken = 0. No error flag.
- Arithmetic wraps modulo 2^XLEN. SRA replicates op_a[XLEN-1].
- FSM states:
  - IDLE: in_ready = 1. On in_valid (and no flush), capture alu_ctrl, op_a and shamt.
    - Non-shift op, or shift with shamt = 0: compute into result, go to DONE.
    - Shift with shamt ≠ 0: load the shift register with op_a, set count = shamt, go to SHIFT.
  - SHIFT: each cycle shift by one position and decrement count. On the cycle count reaches 0, result holds the final value; go to DONE.
  - DONE: out_valid = 1, and result, branch_taken and zero are held stable. On out_ready go to IDLE.
- The shift register is the result register; result is not meaningful while in SHIFT.
- flush has priority over everything in every state: next state is IDLE and out_valid drops. result and branch_taken keep their values but are invalid.
- flush together with in_valid in IDLE: the operation is not accepted.
- Reset (asynchronous, any state, including mid-shift): state = IDLE, in_ready = 1, out_valid = 0, result = 0, branch_taken = 0, zero = 1, count = 0.

## Timing
- Latency from accept edge to out_valid:
  - 1 cycle for non-shift ops and for shamt = 0.
  - 1 + shamt cycles for shifts; the maximum is 32 for XLEN = 32.
- Throughput is at most one op per 2 cycles: DONE must return to IDLE before the next accept. in_ready is low in SHIFT and DONE.
- out_valid stays high, with outputs stable, for as many cycles as out_ready is low. This is the backpressure case.
- All outputs are registered; there is no combinational path from an input to an output. in_ready, out_valid and zero are decoded from registered state.

## Test plan
- ADD and SUB wrap:
  - op_a = 0xFFFF_FFFF, op_b = 1, ctrl 000_000: result = 0, zero = 1, out_valid on the 1st cycle after accept.
  - ctrl 001_000 with op_a = 0, op_b = 1: result 0xFFFF_FFFF.
- Shifts:
  - SRA, op_a = 0x8000_0000, op_b = 31: result 0xFFFF_FFFF, out_valid 32 cycles after accept, in_ready low throughout.
  - SLL with shamt 0: 1-cycle latency, result = op_a.
- Branches:
  - BLT, op_a = 0xFFFF_FFFF, op_b = 1: taken = 1.
  - BLTU with the same operands: taken = 0.
  - func3 010: taken = 0.
- Pass and illegal:
  - ctrl 011_111, op_a = 0x0000_1004: result 0x0000_1004.
  - ctrl 100_000: result 0.
- Backpressure: hold out_ready low 5 cycles in DONE. out_valid and result are stable the whole time and in_ready stays 0. The next op is accepted only after the out_ready handshake.
- Abort:
  - flush mid-SHIFT (count 10): IDLE on the next cycle, out_valid never rises.
  - rst_n low mid-SHIFT: all outputs take their reset values immediately, before the next clock edge.
